fifo_sync_param: RTL and testbench



---
 rtl/fifo_sync_param.sv | 117 +++++++++++
 tb/tb_fifo_sync_param.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with count, almost flags and read strobe.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module fifo_sync_param #(
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic              read,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = ADDR_W + 1;

  localparam logic [ADDR_W:0] DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = CW'(AE_LEVEL);

  if (AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL ||
      AF_LEVEL > DEPTH) begin : g_bad_levels
    $error("fifo_sync_param: illegal AE_LEVEL/AF_LEVEL");
  end

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_acc;
  logic              rd_acc;

  // Flags come from the count register only, so they never glitch.
  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_empty = (count <= AE_C);
  assign almost_full  = (count >= AF_C);

  assign wr_acc = write & ~full;
  assign rd_acc = read & ~empty;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        rd_data <= mem[rd_ptr];
      end
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q;
  logic unf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (write & full);
      unf_q <= unf_q | (read & empty);
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: default 16x8 instance plus
// a 8x16 instance with altered almost-flag levels.
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       write = 1'b0;
  logic       read = 1'b0;
  logic [7:0] wr_data = '0;
  logic [7:0] rd_data;
  logic       rd_valid, empty, full;
  logic       almost_empty, almost_full;
  logic [4:0] count;
  logic       overflow, underflow;

  logic        p_write = 1'b0;
  logic        p_read = 1'b0;
  logic [15:0] p_wr_data = '0;
  logic [15:0] p_rd_data;
  logic        p_rd_valid, p_empty, p_full;
  logic        p_almost_empty, p_almost_full;
  logic [3:0]  p_count;
  logic        p_overflow, p_underflow;

  int checks = 0;
  int fails  = 0;

`ifdef FIFO_ERR_FLAGS_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  fifo_sync_param dut (
    .clk(clk), .reset(reset),
    .write(write), .read(read),
    .wr_data(wr_data), .rd_data(rd_data),
    .rd_valid(rd_valid), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  fifo_sync_param #(
    .WIDTH(16), .ADDR_W(3), .AF_LEVEL(6), .AE_LEVEL(1)
  ) dut_p (
    .clk(clk), .reset(reset),
    .write(p_write), .read(p_read),
    .wr_data(p_wr_data), .rd_data(p_rd_data),
    .rd_valid(p_rd_valid), .empty(p_empty), .full(p_full),
    .almost_empty(p_almost_empty), .almost_full(p_almost_full),
    .count(p_count), .overflow(p_overflow),
    .underflow(p_underflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    step();
    checks++;
    if ({empty, full, almost_empty, almost_full, rd_valid}
        !== 5'b10100) begin
      $display("FAIL reset_flags got %b want 10100",
        {empty, full, almost_empty, almost_full, rd_valid});
      fails++;
    end
    checks++;
    if (count !== 5'd0 || rd_data !== 8'h00) begin
      $display("FAIL reset_cnt_data got %0d/%h want 0/00",
        count, rd_data);
      fails++;
    end
    checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      $display("FAIL reset_err got %b%b want 00",
        overflow, underflow);
      fails++;
    end
  endtask

  task automatic test_reset_mid();
    write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'h60 + 8'(i);
      step();
    end
    write = 1'b0;
    read = 1'b1;
    step();
    read = 1'b0;
    checks++;
    if (count !== 5'd2 || rd_data !== 8'h60) begin
      $display("FAIL pre_reset got %0d/%h want 2/60",
        count, rd_data);
      fails++;
    end
    reset = 1'b0;
    #1;
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || rd_data !== 8'h00) begin
      $display("FAIL async_reset got %0d/%b/%h want 0/1/00",
        count, empty, rd_data);
      fails++;
    end
    #1;
    reset = 1'b1;
    @(negedge clk);
    write = 1'b1;
    wr_data = 8'hA5;
    step();
    write = 1'b0;
    read = 1'b1;
    step();
    read = 1'b0;
    checks++;
    if (rd_data !== 8'hA5 || rd_valid !== 1'b1) begin
      $display("FAIL post_reset_word got %h/%b want a5/1",
        rd_data, rd_valid);
      fails++;
    end
    step();
    checks++;
    if (count !== 5'd0 || rd_valid !== 1'b0) begin
      $display("FAIL post_reset_idle got %0d/%b want 0/0",
        count, rd_valid);
      fails++;
    end
  endtask

  task automatic test_fill();
    write = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wr_data = 8'(i);
      step();
      checks++;
      if (count !== 5'(i) || almost_empty !== (i <= 2) ||
          almost_full !== (i >= 14) || full !== (i == 16) ||
          empty !== 1'b0) begin
        $display("FAIL fill_%0d got c=%0d ae=%b af=%b f=%b e=%b",
          i, count, almost_empty, almost_full, full, empty);
        fails++;
      end
    end
    wr_data = 8'hFF;
    step();
    write = 1'b0;
    checks++;
    if (count !== 5'd16 || overflow !== ERR_ON) begin
      $display("FAIL overflow got c=%0d ov=%b want 16/%b",
        count, overflow, ERR_ON);
      fails++;
    end
  endtask

  task automatic test_drain();
    read = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      checks++;
      if (rd_data !== 8'(i) || rd_valid !== 1'b1 ||
          count !== 5'(16 - i)) begin
        $display("FAIL drain_%0d got d=%h v=%b c=%0d want %h/1/%0d",
          i, rd_data, rd_valid, count, 8'(i), 16 - i);
        fails++;
      end
    end
    checks++;
    if (empty !== 1'b1 || underflow !== 1'b0) begin
      $display("FAIL drain_empty got e=%b uf=%b want 1/0",
        empty, underflow);
      fails++;
    end
    step();
    read = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h10 ||
        underflow !== ERR_ON || count !== 5'd0) begin
      $display("FAIL underflow got v=%b d=%h uf=%b c=%0d",
        rd_valid, rd_data, underflow, count);
      fails++;
    end
  endtask

  task automatic test_wrap();
    for (int pass = 0; pass < 2; pass++) begin
      write = 1'b1;
      for (int i = 0; i < 10; i++) begin
        wr_data = 8'(8'h20 + 16 * pass + i);
        step();
      end
      write = 1'b0;
      read = 1'b1;
      for (int i = 0; i < 10; i++) begin
        step();
        checks++;
        if (rd_data !== 8'(8'h20 + 16 * pass + i) ||
            rd_valid !== 1'b1) begin
          $display("FAIL wrap_%0d_%0d got %h want %h",
            pass, i, rd_data, 8'(8'h20 + 16 * pass + i));
          fails++;
        end
      end
      read = 1'b0;
    end
    checks++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      $display("FAIL wrap_final got %0d want 0", count);
      fails++;
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_q [$];
    write = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'h40 + 8'(i);
      step();
    end
    read = 1'b1;
    wr_data = 8'h50;
    step();
    checks++;
    if (count !== 5'd5 || rd_data !== 8'h40 || rd_valid !== 1'b1) begin
      $display("FAIL rw_mid got c=%0d d=%h want 5/40",
        count, rd_data);
      fails++;
    end
    read = 1'b0;
    for (int i = 0; i < 11; i++) begin
      wr_data = 8'h51 + 8'(i);
      step();
    end
    read = 1'b1;
    wr_data = 8'hEE;
    step();
    write = 1'b0;
    checks++;
    if (count !== 5'd15 || rd_data !== 8'h41) begin
      $display("FAIL rw_full got c=%0d d=%h want 15/41",
        count, rd_data);
      fails++;
    end
    exp_q = '{8'h42, 8'h43, 8'h44, 8'h50};
    for (int i = 0; i < 11; i++) exp_q.push_back(8'h51 + 8'(i));
    for (int i = 0; i < 15; i++) begin
      step();
      checks++;
      if (rd_data !== exp_q[i]) begin
        $display("FAIL rw_full_drain_%0d got %h want %h",
          i, rd_data, exp_q[i]);
        fails++;
      end
    end
    write = 1'b1;
    wr_data = 8'h77;
    step();
    write = 1'b0;
    checks++;
    if (count !== 5'd1 || rd_valid !== 1'b0) begin
      $display("FAIL rw_empty got c=%0d v=%b want 1/0",
        count, rd_valid);
      fails++;
    end
    step();
    read = 1'b0;
    checks++;
    if (rd_data !== 8'h77 || rd_valid !== 1'b1 || count !== 5'd0) begin
      $display("FAIL rw_empty_read got %h/%b/%0d want 77/1/0",
        rd_data, rd_valid, count);
      fails++;
    end
  endtask

  task automatic test_param();
    p_write = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      p_wr_data = (i == 1) ? 16'hBEEF : 16'h1000 + 16'(i);
      step();
      checks++;
      if (p_count !== 4'(i) || p_almost_full !== (i >= 6) ||
          p_almost_empty !== (i <= 1) || p_full !== (i == 8)) begin
        $display("FAIL param_fill_%0d got c=%0d af=%b ae=%b f=%b",
          i, p_count, p_almost_full, p_almost_empty, p_full);
        fails++;
      end
    end
    p_write = 1'b0;
    p_read = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if (p_rd_data !== ((i == 1) ? 16'hBEEF : 16'h1000 + 16'(i))) begin
        $display("FAIL param_read_%0d got %h", i, p_rd_data);
        fails++;
      end
    end
    p_read = 1'b0;
    checks++;
    if (p_empty !== 1'b1) begin
      $display("FAIL param_empty got %b want 1", p_empty);
      fails++;
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_param();
    $display("End of test - %0d assertions evaluated, %0d failures",
      checks, fails);
    $finish;
  end

endmodule
